regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-back queue that sits between the execute/memory result sources and the single register-file write port.
- Accepts result writes (destination, data) through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle into the register file's write-enable/address/data inputs whenever the write port is not stalled.
- Provides a forwarding lookup on both read addresses, so pending (not yet written) values are visible to operand fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DW, 32, data width.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers a write-back.
- in_ready  out  1  queue can accept this cycle.
- in_addr  in  AW  destination register.
- in_data  in  DW  result value.
- wr_stall  in  1  register-file write port unavailable; hold the head entry.
- rf_regWr  out  1  write enable toward the register file.
- rf_Write_import  out  AW  write address toward the register file.
- rf_Write_data  out  DW  write data toward the register file.
- Read_import1  in  AW  operand-1 address being read.
- Read_import2  in  AW  operand-2 address being read.
- fwd_hit1  out  1  a pending entry matches Read_import1.
- fwd_hit2  out  1  a pending entry matches Read_import2.
- fwd_data1  out  DW  forwarded value for operand 1.
- fwd_data2  out  DW  forwarded value for operand 2.
- count  out  clog2(DEPTH)+1  number of stored entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, any time, including mid-drain):
  - wr_ptr = rd_ptr = count = 0.
  - All entry valid bits cleared.
  - rf_regWr = 0, rf_Write_import = 0, rf_Write_data = 0.
  - fwd_hit1/2 = 0, fwd_data1/2 = 0, empty = 1, in_ready = 1.
  - Entry data contents need not be cleared.
- in_ready = (count != DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Push condition: in_valid && in_ready && in_addr != 0.
  - Stores {in_addr, in_data} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - If in_addr == 0, the handshake still completes (accepted) but nothing is stored; R0 writes are discarded.
- Head outputs are combinational from the head entry:
  - rf_regWr = !empty && !wr_stall.
  - rf_Write_import and rf_Write_data = head entry when !empty, otherwise 0.
- Pop condition: !empty && !wr_stall at the clock edge. Advances rd_ptr modulo DEPTH.
  - The register file captures the write on the same edge, so an entry's latency from accept to register-file update is at least 1 cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal at any occupancy below DEPTH.
- Ordering: strictly FIFO. Two writes to the same register are committed in acceptance order.
- Forwarding lookup (combinational, for each read port independently):
  - Searches only stored entries; the in-flight input of the current cycle is excluded.
  - Among valid entries whose address equals Read_import and is non-zero, the youngest (closest to wr_ptr going backward) wins.
  - fwd_hit = 1 on any match, with fwd_data = that entry's data.
  - Otherwise fwd_hit = 0 and fwd_data = 0.
  - Read_import = 0 never hits.
  - The head entry being popped this cycle still hits this cycle.
- wr_stall held high indefinitely: the queue fills to DEPTH, in_ready drops, contents are preserved, and forwarding remains valid.
- count and empty are registered and consistent with the pointers after every edge.

Decomposition:
- Shared package:
  - constants REG_AW = 5, REG_DW = 32, REG_ZERO = 0;
  - a typedef for the entry record {addr, data}.
- One sub-module, regfile_wb_fwd_lookup:
  - a combinational youngest-match priority search over DEPTH entries given valid bits, entries, wr_ptr and one read address;
  - instantiated twice, once per read port.

Test Plan:
- Reset then idle: rst pulsed mid-cycle -> outputs zero immediately, empty = 1, in_ready = 1, rf_regWr = 0.
- Single write: push (addr 3, 0x0000_00AA), wr_stall = 0 -> next cycle rf_regWr = 1, rf_Write_import = 3, rf_Write_data = 0xAA for exactly one cycle, then empty = 1.
- Fill under stall: wr_stall = 1, push addr 1..4 with data 0x11..0x44 -> count = 4, in_ready = 0, a fifth push is not accepted. Release stall -> writes to registers 1, 2, 3, 4 in order on 4 consecutive cycles.
- Forwarding youngest wins: under stall, push (5, 0x10) then (5, 0x20), with Read_import1 = 5 and Read_import2 = 6 -> fwd_hit1 = 1, fwd_data1 = 0x20, fwd_hit2 = 0, fwd_data2 = 0.
- R0 discard: push (0, 0xDEAD) -> handshake completes, count stays 0, rf_regWr never asserts; Read_import1 = 0 -> fwd_hit1 = 0.
- Wrap plus simultaneous push/pop: stream 10 back-to-back pushes with wr_stall = 0 -> count stays at 1 after the first, pointers wrap, all 10 writes are emitted in order with no gaps. Assert rst mid-stream -> queue empties immediately.

Source files
------------

// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and the entry record for the register-file write-back queue.
package regfile_wb_queue_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int REG_ZERO = 0;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's producer, register-file and forwarding signals.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          rf_regWr;
    logic [AW-1:0] rf_Write_import;
    logic [DW-1:0] rf_Write_data;
    logic [AW-1:0] Read_import1;
    logic [AW-1:0] Read_import2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [CW-1:0] count;
    logic          empty;

    // Producer / operand-fetch / register-file side.
    modport master (
        output in_valid, in_addr, in_data, wr_stall, Read_import1, Read_import2,
        input  in_ready, rf_regWr, rf_Write_import, rf_Write_data,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
    );

    // Queue side.
    modport slave (
        input  in_valid, in_addr, in_data, wr_stall, Read_import1, Read_import2,
        output in_ready, rf_regWr, rf_Write_import, rf_Write_data,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
    );

endinterface

// File: rtl/regfile_wb_fwd_lookup.sv
// Youngest-match forwarding search over the queue's stored entries for one read address.
module regfile_wb_fwd_lookup
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    addr_mem [DEPTH],
    input  logic [DW-1:0]    data_mem [DEPTH],
    input  logic [PW-1:0]    wr_ptr,
    input  logic [AW-1:0]    rd_addr,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    idx;

    // Register 0 is never pending, so a zero read address can never match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid[gi] && (addr_mem[gi] == rd_addr)
                               && (rd_addr != AW'(REG_ZERO));
        end
    endgenerate

    // Walk entries from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1); the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PW'(k);
            if (match[idx]) begin
                hit  = 1'b1;
                data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO in front of the single register-file write port, with
// operand forwarding of values that are accepted but not yet written.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             empty_reg, empty_next;
    logic [DEPTH-1:0] valid_reg, valid_next;

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    logic full;
    logic accept;
    logic push;
    logic pop;

    // No pass-through when full: a pop in the same cycle does not free a slot early.
    assign full   = (count_reg == FULL_COUNT);
    assign accept = bus.in_valid && !full;
    // R0 writes complete the handshake but are dropped.
    assign push   = accept && (bus.in_addr != AW'(REG_ZERO));
    assign pop    = !empty_reg && !bus.wr_stall;

    assign wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    assign rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    assign count_next  = count_reg + CW'(push) - CW'(pop);
    assign empty_next  = (count_next == '0);

    // Per-slot occupancy: set by a write into the slot, cleared when the slot drains.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_next[gi] = (push && (wr_ptr_reg == PW'(gi))) ? 1'b1 :
                                    (pop  && (rd_ptr_reg == PW'(gi))) ? 1'b0 :
                                    valid_reg[gi];
        end
    endgenerate

    // Pointer, occupancy and slot-valid state; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            valid_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            empty_reg  <= empty_next;
            valid_reg  <= valid_next;
        end
    end

    // Entry payload storage; contents are only meaningful while the slot is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= bus.in_addr;
            data_mem[wr_ptr_reg] <= bus.in_data;
        end
    end

    // Head entry drives the register-file write port; zeros when nothing is pending.
    assign bus.rf_regWr        = pop;
    assign bus.rf_Write_import = empty_reg ? '0 : addr_mem[rd_ptr_reg];
    assign bus.rf_Write_data   = empty_reg ? '0 : data_mem[rd_ptr_reg];

    assign bus.in_ready = !full;
    assign bus.count    = count_reg;
    assign bus.empty    = empty_reg;

    regfile_wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fwd1 (
        .valid    (valid_reg),
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .wr_ptr   (wr_ptr_reg),
        .rd_addr  (bus.Read_import1),
        .hit      (bus.fwd_hit1),
        .data     (bus.fwd_data1)
    );

    regfile_wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fwd2 (
        .valid    (valid_reg),
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .wr_ptr   (wr_ptr_reg),
        .rd_addr  (bus.Read_import2),
        .hit      (bus.fwd_hit2),
        .data     (bus.fwd_data2)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for the write-back queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of pending register writes.
module tb_regfile_wb_queue;
    import regfile_wb_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = REG_DW;
    localparam int AW    = REG_AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Pending writes in acceptance order; front is the next one the register file sees.
    wb_entry_t model_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending value for a register, if any.
    task automatic fwd_ref(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].addr == a) begin
                    h = 1'b1;
                    d = model_q[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        int            n;
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
        n = model_q.size();
        fwd_ref(bus.Read_import1, h1, d1);
        fwd_ref(bus.Read_import2, h2, d2);
        chk("count",    32'(bus.count),    32'(n));
        chk("empty",    32'(bus.empty),    32'(n == 0));
        chk("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
        chk("rf_regWr", 32'(bus.rf_regWr), 32'((n > 0) && !bus.wr_stall));
        chk("rf_addr",  32'(bus.rf_Write_import), (n > 0) ? 32'(model_q[0].addr) : 32'd0);
        chk("rf_data",  32'(bus.rf_Write_data),   (n > 0) ? 32'(model_q[0].data) : 32'd0);
        chk("fwd_hit1",  32'(bus.fwd_hit1),  32'(h1));
        chk("fwd_data1", 32'(bus.fwd_data1), 32'(d1));
        chk("fwd_hit2",  32'(bus.fwd_hit2),  32'(h2));
        chk("fwd_data2", 32'(bus.fwd_data2), 32'(d2));
    endtask

    // Apply inputs just after a falling edge, then check the model before the next rising edge.
    task automatic drive(input int v, input int a, input logic [DW-1:0] d, input int s,
                         input int r1, input int r2);
        bus.in_valid     = (v != 0);
        bus.in_addr      = AW'(a);
        bus.in_data      = d;
        bus.wr_stall     = (s != 0);
        bus.Read_import1 = AW'(r1);
        bus.Read_import2 = AW'(r2);
        #1;
        check_model();
        $display("txn t=%0t v=%0b a=%0d d=%h st=%0b | rdy=%0b wr=%0b wa=%0d wd=%h cnt=%0d h1=%0b/%h h2=%0b/%h",
                 $time, bus.in_valid, bus.in_addr, bus.in_data, bus.wr_stall, bus.in_ready,
                 bus.rf_regWr, bus.rf_Write_import, bus.rf_Write_data, bus.count,
                 bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic step_clk();
        logic      acc, pop;
        wb_entry_t e;
        acc    = bus.in_valid && (model_q.size() < DEPTH);
        pop    = (model_q.size() > 0) && !bus.wr_stall;
        e.addr = bus.in_addr;
        e.data = bus.in_data;
        @(posedge clk);
        if (pop) void'(model_q.pop_front());
        if (acc && (e.addr != '0)) model_q.push_back(e);
        @(negedge clk);
    endtask

    // Pulse reset in the middle of the low clock phase and check it acts without a clock edge.
    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        check_model();
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_regWr",    32'(bus.rf_regWr), 32'd0);
        $display("txn t=%0t reset pulse", $time);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_addr      = '0;
        bus.in_data      = '0;
        bus.wr_stall     = 1'b0;
        bus.Read_import1 = 5'd3;
        bus.Read_import2 = 5'd4;
        @(negedge clk);

        // Reset then idle.
        do_reset();
        drive(0, 0, 32'h0, 0, 3, 4);
        step_clk();

        // Single write appears on the write port for exactly one cycle.
        drive(1, 3, 32'h0000_00AA, 0, 3, 0);
        chk("single_in_ready", 32'(bus.in_ready), 32'd1);
        chk("single_no_early_fwd", 32'(bus.fwd_hit1), 32'd0);
        step_clk();
        drive(0, 0, 32'h0, 0, 3, 0);
        chk("single_regWr", 32'(bus.rf_regWr), 32'd1);
        chk("single_addr",  32'(bus.rf_Write_import), 32'd3);
        chk("single_data",  32'(bus.rf_Write_data), 32'h0000_00AA);
        chk("single_head_fwd", 32'(bus.fwd_data1), 32'h0000_00AA);
        step_clk();
        drive(0, 0, 32'h0, 0, 3, 0);
        chk("single_done_regWr", 32'(bus.rf_regWr), 32'd0);
        chk("single_done_empty", 32'(bus.empty), 32'd1);
        step_clk();

        // Fill under stall, refuse a fifth write, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 32'(i * 'h11), 1, 0, 0);
            step_clk();
        end
        drive(1, 5, 32'h55, 1, 2, 4);
        chk("full_count",    32'(bus.count),    32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_fwd2",     32'(bus.fwd_data2), 32'h44);
        step_clk();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            chk("drain_regWr", 32'(bus.rf_regWr), 32'd1);
            chk("drain_addr",  32'(bus.rf_Write_import), 32'(i));
            chk("drain_data",  32'(bus.rf_Write_data), 32'(i * 'h11));
            step_clk();
        end
        drive(0, 0, 32'h0, 0, 0, 0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        step_clk();

        // Two pending writes to one register: the younger one forwards.
        drive(1, 5, 32'h10, 1, 5, 6);
        step_clk();
        drive(1, 5, 32'h20, 1, 5, 6);
        step_clk();
        drive(0, 0, 32'h0, 1, 5, 6);
        chk("young_hit1",  32'(bus.fwd_hit1),  32'd1);
        chk("young_data1", 32'(bus.fwd_data1), 32'h20);
        chk("young_hit2",  32'(bus.fwd_hit2),  32'd0);
        chk("young_data2", 32'(bus.fwd_data2), 32'd0);
        step_clk();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 5, 6);
            step_clk();
        end

        // R0 writes are accepted and discarded.
        drive(1, 0, 32'h0000_DEAD, 0, 0, 0);
        chk("r0_in_ready", 32'(bus.in_ready), 32'd1);
        step_clk();
        drive(0, 0, 32'h0, 0, 0, 0);
        chk("r0_count", 32'(bus.count),    32'd0);
        chk("r0_regWr", 32'(bus.rf_regWr), 32'd0);
        chk("r0_hit1",  32'(bus.fwd_hit1), 32'd0);
        step_clk();

        // Back-to-back stream: occupancy stays at one, pointers wrap, no gaps.
        for (int i = 0; i < 10; i++) begin
            drive(1, (i % 7) + 1, 32'(32'h100 + i), 0, 0, 0);
            if (i > 0) begin
                chk("stream_count", 32'(bus.count), 32'd1);
                chk("stream_addr",  32'(bus.rf_Write_import), 32'(((i - 1) % 7) + 1));
                chk("stream_data",  32'(bus.rf_Write_data), 32'(32'h100 + i - 1));
            end
            step_clk();
        end
        drive(0, 0, 32'h0, 0, 0, 0);
        chk("stream_last", 32'(bus.rf_Write_data), 32'h109);
        step_clk();

        // Reset in the middle of a stream empties the queue at once.
        drive(1, 9, 32'h900, 1, 9, 10);
        step_clk();
        drive(1, 10, 32'hA00, 1, 9, 10);
        step_clk();
        do_reset();
        drive(0, 0, 32'h0, 0, 9, 10);
        chk("post_rst_empty", 32'(bus.empty), 32'd1);
        step_clk();

        // Random traffic with a small address range to provoke forwarding collisions.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                drive(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 2) == 0) ? 1 : 0,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                step_clk();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
